regfile_mp: RTL

//   Parametrised multi-port integer register file for the pipelined RISC-V core.

---
 rtl/regfile_mp.sv | 106 ++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file with a built-in clear sequencer; x0 reads as zero.
// Optional same-cycle write-to-read forwarding is enabled by defining WRITE_BYPASS_EN.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_req,
  output logic                    ready,
  input  logic [NREAD*AW-1:0]     ra,
  output logic [NREAD*XLEN-1:0]   rd,
  input  logic [NWRITE-1:0]       we,
  input  logic [NWRITE*AW-1:0]    wa,
  input  logic [NWRITE*XLEN-1:0]  wd
);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t          state, state_n;
  logic [AW-1:0]   cnt, cnt_n;
  logic            clearing;
  logic            wr_ok;
  logic [XLEN-1:0] mem [NREGS];

  logic [AW-1:0]   ra_v [NREAD];
  logic [AW-1:0]   wa_v [NWRITE];
  logic [XLEN-1:0] wd_v [NWRITE];

  for (genvar i = 0; i < NREAD; i++) begin : g_ra
    assign ra_v[i] = ra[i*AW +: AW];
  end
  for (genvar j = 0; j < NWRITE; j++) begin : g_wr
    assign wa_v[j] = wa[j*AW +: AW];
    assign wd_v[j] = wd[j*XLEN +: XLEN];
  end

  // ready is a level, not a handshake: writes are accepted only on edges where
  // ready=1 and clr_req=0; the pipeline must hold issue while ready=0.
  assign ready = (state == READY);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= AW'(1);
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    clearing = 1'b0;
    wr_ok    = 1'b0;
    case (state)
      CLEAR: begin
        clearing = 1'b1;
        cnt_n    = cnt + AW'(1);
        if (cnt == AW'(NREGS - 1)) state_n = READY;
      end
      READY: begin
        if (clr_req) begin
          state_n = CLEAR;
          cnt_n   = AW'(1);
        end else begin
          wr_ok = 1'b1;
        end
      end
      default: state_n = CLEAR;
    endcase
  end

  // Later loop iterations override earlier ones, so the highest-index port wins.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (clearing) begin
        mem[cnt] <= '0;
      end else if (wr_ok) begin
        for (int j = 0; j < NWRITE; j++) begin
          if (we[j] && (wa_v[j] != '0)) mem[wa_v[j]] <= wd_v[j];
        end
      end
    end
  end

  always_comb begin
    rd = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (ready && (ra_v[i] != '0)) begin
        rd[i*XLEN +: XLEN] = mem[ra_v[i]];
`ifdef WRITE_BYPASS_EN
        for (int j = 0; j < NWRITE; j++) begin
          if (wr_ok && we[j] && (wa_v[j] == ra_v[i])) rd[i*XLEN +: XLEN] = wd_v[j];
        end
`else
`endif
      end
    end
  end

endmodule
